// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath blocks.
//   state_t         : accumulator controller states
//   EXC_*           : bit positions inside the 5-bit exception vector
//                     {invalid, infinite, overflow, underflow, inexact}
//   RM_*            : rounding-mode encodings accepted by the FP adder
//   POS_ZERO/CANON_NAN : single-precision reference constants
//   word_w()        : packed FP word width from exponent/significand widths
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      BIAS  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int EXC_INVALID   = 4;
   localparam int EXC_INFINITE  = 3;
   localparam int EXC_OVERFLOW  = 2;
   localparam int EXC_UNDERFLOW = 1;
   localparam int EXC_INEXACT   = 0;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   localparam logic [31:0] POS_ZERO  = 32'h0000_0000;
   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   function automatic int word_w(input int exp_width, input int mant_width);
      return exp_width + mant_width;
   endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / result-out streams of the MAC accumulator.
//   in_valid/in_ready/in_data/in_exc     : product stream from the multiplier
//   out_valid/out_ready/out_data/out_exc : result stream to the next layer stage
// Modports: master = stream producer/consumer side (bench or neighbours),
//           slave  = accumulator side.
interface mac_accumulator_if
   import nn_pkg::*;
#(
   parameter int exp_width  = 8,
   parameter int mant_width = 24
);
   localparam int W = word_w(exp_width, mant_width);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [4:0]   in_exc;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [4:0]   out_exc;

   modport master (
      output in_valid, in_data, in_exc, out_ready,
      input  in_ready, out_valid, out_data, out_exc
   );

   modport slave (
      input  in_valid, in_data, in_exc, out_ready,
      output in_ready, out_valid, out_data, out_exc
   );
endinterface

// File: rtl/mac_accumulator_fpadd.sv
// Combinational IEEE-style FP adder (sign | exponent | fraction, hidden bit implied).
//   a, b       : operands
//   round_mode : RNE/RTZ/RDN/RUP/RMM (nn_pkg RM_* encodings)
//   result     : rounded sum; any NaN operand or Inf-Inf yields the canonical quiet NaN
//   exc        : {invalid, infinite, overflow, underflow, inexact}
module mac_accumulator_fpadd
   import nn_pkg::*;
#(
   parameter int exp_width  = 8,
   parameter int mant_width = 24
) (
   input  logic [exp_width+mant_width-1:0] a,
   input  logic [exp_width+mant_width-1:0] b,
   input  logic [2:0]                      round_mode,
   output logic [exp_width+mant_width-1:0] result,
   output logic [4:0]                      exc
);
   localparam int W = word_w(exp_width, mant_width);
   localparam int F = mant_width - 1;           // stored fraction bits
   localparam int X = mant_width + 3;           // significand plus guard/round/sticky
   localparam logic [exp_width-1:0] EMAX = '1;
   localparam logic [exp_width-1:0] EONE = {{(exp_width-1){1'b0}}, 1'b1};
   localparam logic signed [exp_width+1:0] ES1 = (exp_width+2)'(1);
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(F-1){1'b0}}};

   function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic r,
                                     input logic s);
      case (rm)
         RM_RTZ:  return 1'b0;
         RM_RDN:  return sign & (g | r | s);
         RM_RUP:  return !sign & (g | r | s);
         RM_RMM:  return g;
         default: return g & (r | s | lsb);
      endcase
   endfunction

   function automatic int lzc(input logic [X-1:0] v);
      int n;
      n = X;
      for (int i = 0; i < X; i++) if (v[i]) n = X - 1 - i;
      return n;
   endfunction

   function automatic logic [W+4:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] rm);
      logic sx, sy, sl, ss, sr, sub, inc, st;
      logic [exp_width-1:0] ex, ey, el, es;
      logic [F-1:0] fx, fy;
      logic [X-1:0] ml, ms;
      logic [X:0] sum;
      logic [mant_width:0] rnd;
      logic signed [exp_width+1:0] e_r;
      logic [4:0] fl;
      int d, lz;
      {sx, ex, fx} = x;
      {sy, ey, fy} = y;
      fl = '0;
      // NaN operands: only a signalling NaN (quiet bit clear) raises invalid
      if ((&ex && |fx) || (&ey && |fy)) begin
         fl[EXC_INVALID] = (&ex && |fx && !fx[F-1]) || (&ey && |fy && !fy[F-1]);
         return {fl, QNAN};
      end
      if (&ex && &ey && (sx != sy)) begin
         fl[EXC_INVALID] = 1'b1;
         return {fl, QNAN};
      end
      if (&ex) return {fl, x};
      if (&ey) return {fl, y};
      // Larger magnitude becomes the "l" operand so the difference is never negative
      if ({ex, fx} >= {ey, fy}) begin
         sl = sx; el = ex; ml = {|ex, fx, 3'b000};
         ss = sy; es = ey; ms = {|ey, fy, 3'b000};
      end else begin
         sl = sy; el = ey; ml = {|ey, fy, 3'b000};
         ss = sx; es = ex; ms = {|ex, fx, 3'b000};
      end
      // Subnormals share the minimum exponent with a zero hidden bit
      if (el == '0) el = EONE;
      if (es == '0) es = EONE;
      d = int'(el) - int'(es);
      if (d >= X) begin
         ms = {{(X-1){1'b0}}, |ms};
      end else begin
         st = 1'b0;
         for (int i = 0; i < X; i++) if (i < d && ms[i]) st = 1'b1;
         ms = ms >> d;
         ms[0] = ms[0] | st;
      end
      sub = sl ^ ss;
      sum = sub ? ({1'b0, ml} - {1'b0, ms}) : ({1'b0, ml} + {1'b0, ms});
      // Exact cancellation gives +0, except -0 when rounding down
      if (sum == '0) return {fl, (sub ? (rm == RM_RDN) : sl), {(W-1){1'b0}}};
      sr  = sl;
      e_r = $signed({2'b00, el});
      if (sum[X]) begin
         sum = {1'b0, sum[X:2], sum[1] | sum[0]};
         e_r = e_r + ES1;
      end else begin
         // Left-normalise, but never below the minimum exponent (result stays subnormal)
         lz = lzc(sum[X-1:0]);
         if (lz > int'(e_r) - 1) lz = int'(e_r) - 1;
         sum = sum << lz;
         e_r = e_r - (exp_width+2)'(lz);
      end
      inc = round_up(rm, sr, sum[3], sum[2], sum[1], sum[0]);
      rnd = {1'b0, sum[X-1:3]} + {{mant_width{1'b0}}, inc};
      if (rnd[mant_width]) begin
         rnd = rnd >> 1;
         e_r = e_r + ES1;
      end
      fl[EXC_INEXACT] = |sum[2:0];
      if (e_r >= $signed({2'b00, EMAX})) begin
         fl[EXC_OVERFLOW] = 1'b1;
         fl[EXC_INEXACT]  = 1'b1;
         if (rm == RM_RTZ || (rm == RM_RDN && !sr) || (rm == RM_RUP && sr))
            return {fl, sr, EMAX ^ EONE, {F{1'b1}}};
         return {fl, sr, EMAX, {F{1'b0}}};
      end
      fl[EXC_UNDERFLOW] = !rnd[mant_width-1] && fl[EXC_INEXACT];
      return {fl, sr, (rnd[mant_width-1] ? e_r[exp_width-1:0] : {exp_width{1'b0}}), rnd[F-1:0]};
   endfunction

   assign {exc, result} = fp_add(a, b, round_mode);

endmodule

// File: rtl/mac_accumulator.sv
// Sequential dot-product accumulator: sums num_terms products arriving on the
// bus input stream, adds a bias and presents one result with sticky flags.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : begin a job (sampled in IDLE only); latches num_terms, bias, round_mode
//   busy       : registered, high whenever the controller is not in IDLE
//   bus        : mac_accumulator_if.slave (product stream in, result stream out)
// Build option: define RELU_EN to clamp negative non-NaN results to +0 at the output.
module mac_accumulator
   import nn_pkg::*;
#(
   parameter int exp_width  = 8,
   parameter int mant_width = 24,
   parameter int len_width  = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [len_width-1:0]            num_terms,
   input  logic [exp_width+mant_width-1:0] bias,
   input  logic [2:0]                      round_mode,
   output logic                            busy,
   mac_accumulator_if.slave                bus
);
   localparam int W = word_w(exp_width, mant_width);
   localparam logic [len_width-1:0] CNT_ONE = {{(len_width-1){1'b0}}, 1'b1};

   state_t               state, nstate;
   logic [len_width-1:0] num_q, count;
   logic [W-1:0]         bias_q, acc, add_b, add_sum, biased;
   logic [W-1:0]         out_data_r;
   logic [2:0]           rm_q;
   logic [4:0]           add_exc, exc_sticky, out_exc_r;
   logic                 out_valid_r, in_ready_c, hs;

   // Single adder shared between the accumulate and bias steps
   mac_accumulator_fpadd #(
      .exp_width (exp_width),
      .mant_width(mant_width)
   ) u_fpadd (
      .a         (acc),
      .b         (add_b),
      .round_mode(rm_q),
      .result    (add_sum),
      .exc       (add_exc)
   );

`ifdef RELU_EN
   // Any sign-set non-NaN result (including -0) is clamped to +0
   assign biased = (add_sum[W-1] && !(&add_sum[W-2:mant_width-1] && |add_sum[mant_width-2:0]))
                   ? '0 : add_sum;
`else
   assign biased = add_sum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start) nstate = (num_terms == '0) ? BIAS : ACCUM;
         ACCUM:   if (hs && (count == num_q - CNT_ONE)) nstate = BIAS;
         BIAS:    nstate = DONE;
         DONE:    if (bus.out_ready) nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      in_ready_c = (state == ACCUM);
      hs         = in_ready_c && bus.in_valid;
      add_b      = (state == BIAS) ? bias_q : bus.in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_q       <= '0;
         bias_q      <= '0;
         rm_q        <= '0;
         acc         <= '0;
         count       <= '0;
         exc_sticky  <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_exc_r   <= '0;
         busy        <= 1'b0;
      end else begin
         busy <= (nstate != IDLE);
         case (state)
            IDLE: if (start) begin
               num_q      <= num_terms;
               bias_q     <= bias;
               rm_q       <= round_mode;
               acc        <= '0;
               count      <= '0;
               exc_sticky <= '0;
            end
            ACCUM: if (hs) begin
               acc        <= add_sum;
               exc_sticky <= exc_sticky | bus.in_exc | add_exc;
               count      <= count + CNT_ONE;
            end
            BIAS: begin
               acc         <= add_sum;
               exc_sticky  <= exc_sticky | add_exc;
               out_data_r  <= biased;
               out_exc_r   <= exc_sticky | add_exc;
               out_valid_r <= 1'b1;
            end
            DONE: if (bus.out_ready) out_valid_r <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_exc   = out_exc_r;

endmodule
